rs_decoder_arbiter: RTL and testbench
=====================================

// Module: rs_decoder_arbiter
// PURPOSE
//  Shares one RS decoder between two codeword sources (ch0, ch1). Grants whole codewords round-robin,
//  pushes the granted channel ID into a tag FIFO at codeword start. Routes decoder output beats back to
//  the owning sink by tag; pops the tag on the accepted end beat. Sits between framing sources and the decoder.
// PARAMETERS
//  word_length   8   symbol width (bits)
//  n             15  max symbols per codeword; length guard
//  k             11  message symbols; informational only, no logic depends on it
//  MAX_INFLIGHT  4   tag FIFO depth (power of 2, >=2): max codewords granted but not fully returned
// PORTS
//  clk             in   1      clock
//  rst             in   1      async reset, active-high
//  req_valid       in   2      per-channel input beat valid
//  req_start       in   2      per-channel start-of-codeword flag
//  req_end         in   2      per-channel end-of-codeword flag
//  req_symbol      in   2*WL   ch0 in [WL-1:0], ch1 in [2WL-1:WL]
//  req_ready       out  2      per-channel beat accepted
//  i_valid         out  1      to decoder: beat valid
//  i_start_codeword out 1      to decoder: start flag
//  i_end_codeword  out  1      to decoder: end flag; forced on nth beat
//  i_symbol        out  WL     to decoder: symbol
//  o_in_ready      in   1      from decoder: input ready
//  o_valid, o_start_codeword, o_end_codeword, o_error  in 1 each  decoder output beat
//  o_symbol        in   WL     decoder output symbol
//  i_consume       out  1      to decoder: output beat consumed
//  resp_valid      out  2      per-sink valid; start/end/error/symbol broadcast unqualified
//  resp_consume    in   2      per-sink consume
//  inflight        out  clog2(MAX_INFLIGHT)+1  tag FIFO occupancy
//  framing_err     out  1      sticky framing error; cleared by reset only
//  err_cnt0/1      out  16 each  per-channel errored-codeword count (see CONFIGURATION)
// BEHAVIOUR
//  Reset: async. FSM=IDLE, rr_ptr=0 (ch0 preferred), FIFO empty, beat count=0, framing_err=0, counters=0.
//   All outputs 0 while rst=1.
//  FSM IDLE:
//   - Candidate: channel with req_valid&req_start; tie -> channel == rr_ptr.
//   - Grant only if inflight<MAX_INFLIGHT. Next cycle -> BUSY, owner=cand; one-cycle arbitration bubble.
//   - No symbols pass in IDLE.
//   - Valid beat without start: req_ready=1, beat discarded, framing_err<=1.
//  FSM BUSY:
//   - i_valid/start/end/symbol = owner's req_*; req_ready[owner]=o_in_ready, other ready=0.
//   - Accept = i_valid&o_in_ready. First accepted beat pushes owner tag.
//   - Beat count (0..n-1) increments per accept.
//   - Accepted end beat -> IDLE, rr_ptr<=~owner, count<=0.
//   - nth accepted beat ends codeword: i_end_codeword forced 1; framing_err<=1 if req_end was 0.
//   - req_start mid-codeword: passed through, no regrant.
//  Output routing (combinational):
//   - tag=FIFO head. resp_valid[tag]=o_valid&!empty; i_consume=resp_consume[tag].
//   - Pop on o_valid&i_consume&o_end_codeword.
//   - o_valid with FIFO empty: i_consume=1 (drain), framing_err<=1.
//  Push and pop in the same cycle: both occur, inflight unchanged.
//  Full FIFO: IDLE holds and BUSY owner unaffected; push cannot overflow because grant checks occupancy.
//  inflight registered; range 0..MAX_INFLIGHT.
// CONFIGURATION
//  RS_ARB_ERR_CNT_EN defined:
//   - Per-tag latch records o_error on any consumed beat of the returning codeword.
//   - At pop, err_cnt[tag] increments if latch set; saturates at 16'hFFFF; latch cleared.
//  RS_ARB_ERR_CNT_EN undefined: err_cnt0/1 tied 16'h0, no counter logic.
// TESTING
//  T1 ch0 only, two 15-beat codewords, decoder always ready:
//     -> beats forwarded, one bubble cycle between codewords, tags 0,0, resp_valid[0] only.
//  T2 ch0 and ch1 start same cycle, rr_ptr=0:
//     -> ch0 granted first, then ch1.
//     -> Output codewords routed to sinks 0 then 1; inflight peaks at 2.
//  T3 MAX_INFLIGHT=4, sinks stall (resp_consume=0), 5 codewords offered:
//     -> 4 granted, inflight=4, 5th held until first pop.
//  T4 ch1 sends 15 beats without req_end:
//     -> i_end_codeword=1 on beat 15, framing_err=1, FSM back to IDLE.
//  T5 rst asserted mid-codeword (beat 7):
//     -> outputs 0 immediately, FIFO empty, next grant from ch0.
//  T6 RS_ARB_ERR_CNT_EN, ch1 codeword with o_error=1 on beat 3:
//     -> err_cnt1=1 after end beat, err_cnt0=0.

Source files
------------

// File: rtl/rs_decoder_arbiter.sv
// rtl/rs_decoder_arbiter.sv - two-channel round-robin front end sharing one RS decoder
//
// Purpose: grants whole codewords from ch0/ch1 to a single RS decoder, records the
// owner of every granted codeword in a tag FIFO, and steers the decoder's output
// beats back to the owning sink using the FIFO head.
//
// Optional feature: define RS_ARB_ERR_CNT_EN to enable per-channel errored-codeword
// counters on err_cnt0/err_cnt1 (tied to zero otherwise).
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/start/end [1:0]     per-channel input beat qualifiers
//   req_symbol [2*WL-1:0]         ch0 in low lane, ch1 in high lane
//   req_ready [1:0]               per-channel beat accepted
//   i_valid/start/end/symbol      beat towards the decoder
//   o_in_ready                    decoder input ready
//   o_valid/start/end/error/symbol decoder output beat
//   i_consume                     decoder output beat consumed
//   resp_valid [1:0]              per-sink valid (other fields taken straight from o_*)
//   resp_consume [1:0]            per-sink consume
//   inflight                      tag FIFO occupancy
//   framing_err                   sticky framing error
//   err_cnt0/1                    per-channel errored-codeword counters
module rs_decoder_arbiter #(
  parameter int word_length  = 8,
  parameter int n            = 15,
  parameter int k            = 11,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    req_valid,
  input  logic [1:0]                    req_start,
  input  logic [1:0]                    req_end,
  input  logic [2*word_length-1:0]      req_symbol,
  output logic [1:0]                    req_ready,
  output logic                          i_valid,
  output logic                          i_start_codeword,
  output logic                          i_end_codeword,
  output logic [word_length-1:0]        i_symbol,
  input  logic                          o_in_ready,
  input  logic                          o_valid,
  input  logic                          o_start_codeword,
  input  logic                          o_end_codeword,
  input  logic                          o_error,
  input  logic [word_length-1:0]        o_symbol,
  output logic                          i_consume,
  output logic [1:0]                    resp_valid,
  input  logic [1:0]                    resp_consume,
  output logic [$clog2(MAX_INFLIGHT):0] inflight,
  output logic                          framing_err,
  output logic [15:0]                   err_cnt0,
  output logic [15:0]                   err_cnt1
);

  localparam int AW = $clog2(MAX_INFLIGHT);
  localparam int CW = $clog2(n);
  localparam logic [AW:0]   FULL     = (AW+1)'(MAX_INFLIGHT);
  localparam logic [CW-1:0] LAST_BEAT = CW'(n-1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state_q, state_d;
  logic                    rr_q, rr_d;
  logic                    owner_q, owner_d;
  logic [CW-1:0]           beat_q, beat_d;
  logic                    ferr_q, ferr_d;
  logic [MAX_INFLIGHT-1:0] tag_mem_q;
  logic [AW-1:0]           wr_q, rd_q;
  logic [AW:0]             cnt_q;

  logic       push, pop, empty, tag, accept, len_end;
  logic [1:0] start_req, idle_drop;

  // Decoder start flag and symbol are passed to sinks directly; k is informational.
  logic unused_ok;
  assign unused_ok = ^{o_start_codeword, o_symbol, o_error, k[0]};

  assign empty       = (cnt_q == '0);
  assign tag         = tag_mem_q[rd_q];
  assign start_req   = req_valid & req_start;
  assign idle_drop   = req_valid & ~req_start;
  assign inflight    = cnt_q;
  assign framing_err = ferr_q;

  always_comb begin
    state_d          = state_q;
    rr_d             = rr_q;
    owner_d          = owner_q;
    beat_d           = beat_q;
    ferr_d           = ferr_q;
    req_ready        = '0;
    i_valid          = 1'b0;
    i_start_codeword = 1'b0;
    i_end_codeword   = 1'b0;
    i_symbol         = '0;
    push             = 1'b0;
    accept           = 1'b0;
    len_end          = 1'b0;
    resp_valid       = '0;
    i_consume        = 1'b0;

    case (state_q)
      IDLE: begin
        // Mid-codeword beats with no owner are swallowed and flagged.
        req_ready = idle_drop;
        if (|idle_drop) ferr_d = 1'b1;
        if ((|start_req) && (cnt_q < FULL)) begin
          state_d = BUSY;
          owner_d = (start_req == 2'b11) ? rr_q : start_req[1];
        end
      end
      BUSY: begin
        len_end          = (beat_q == LAST_BEAT);
        i_valid          = req_valid[owner_q];
        i_start_codeword = req_start[owner_q];
        i_end_codeword   = req_end[owner_q] | len_end;
        i_symbol         = owner_q ? req_symbol[2*word_length-1:word_length]
                                   : req_symbol[word_length-1:0];
        req_ready[owner_q] = o_in_ready;
        accept           = i_valid & o_in_ready;
        if (accept) begin
          push   = (beat_q == '0);
          beat_d = beat_q + 1'b1;
          if (len_end && !req_end[owner_q]) ferr_d = 1'b1;
          if (i_end_codeword) begin
            state_d = IDLE;
            rr_d    = ~owner_q;
            beat_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Output routing follows the oldest outstanding tag; with nothing
    // outstanding the decoder output is drained and flagged.
    if (!empty) begin
      resp_valid[tag] = o_valid;
      i_consume       = resp_consume[tag];
    end else begin
      i_consume = o_valid;
      if (o_valid) ferr_d = 1'b1;
    end
    pop = o_valid & i_consume & o_end_codeword & ~empty;

    if (rst) begin
      req_ready = '0;
      i_consume = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      owner_q   <= 1'b0;
      beat_q    <= '0;
      ferr_q    <= 1'b0;
      tag_mem_q <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      beat_q  <= beat_d;
      ferr_q  <= ferr_d;
      if (push) begin
        tag_mem_q[wr_q] <= owner_q;
        wr_q            <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

`ifdef RS_ARB_ERR_CNT_EN
  logic [1:0]  err_lat_q;
  logic [15:0] err_cnt_q [2];
  logic        consumed;

  assign consumed = o_valid & i_consume & ~empty;

  // The end beat's own error flag counts, so it is folded in at pop time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_lat_q    <= '0;
      err_cnt_q[0] <= '0;
      err_cnt_q[1] <= '0;
    end else if (consumed) begin
      if (pop) begin
        err_lat_q[tag] <= 1'b0;
        if ((err_lat_q[tag] | o_error) && (err_cnt_q[tag] != 16'hFFFF))
          err_cnt_q[tag] <= err_cnt_q[tag] + 16'd1;
      end else if (o_error) begin
        err_lat_q[tag] <= 1'b1;
      end
    end
  end

  assign err_cnt0 = err_cnt_q[0];
  assign err_cnt1 = err_cnt_q[1];
`else
  assign err_cnt0 = 16'h0;
  assign err_cnt1 = 16'h0;
`endif

endmodule

// File: tb/tb_rs_decoder_arbiter.sv
// tb/tb_rs_decoder_arbiter.sv - directed self-checking bench for rs_decoder_arbiter
module tb_rs_decoder_arbiter;

`ifdef RS_ARB_ERR_CNT_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rv [2];
  logic        rs [2];
  logic        re [2];
  logic [7:0]  sym [2];
  logic [1:0]  req_valid, req_start, req_end;
  logic [15:0] req_symbol;
  logic [1:0]  req_ready;
  logic        i_valid, i_start_codeword, i_end_codeword;
  logic [7:0]  i_symbol;
  logic        o_in_ready;
  logic        o_valid, o_start_codeword, o_end_codeword, o_error;
  logic [7:0]  o_symbol;
  logic        i_consume;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_consume;
  logic [2:0]  inflight;
  logic        framing_err;
  logic [15:0] err_cnt0, err_cnt1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int f0, l0, f1, l1, pc;

  assign req_valid  = {rv[1], rv[0]};
  assign req_start  = {rs[1], rs[0]};
  assign req_end    = {re[1], re[0]};
  assign req_symbol = {sym[1], sym[0]};

  rs_decoder_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_start        (req_start),
    .req_end          (req_end),
    .req_symbol       (req_symbol),
    .req_ready        (req_ready),
    .i_valid          (i_valid),
    .i_start_codeword (i_start_codeword),
    .i_end_codeword   (i_end_codeword),
    .i_symbol         (i_symbol),
    .o_in_ready       (o_in_ready),
    .o_valid          (o_valid),
    .o_start_codeword (o_start_codeword),
    .o_end_codeword   (o_end_codeword),
    .o_error          (o_error),
    .o_symbol         (o_symbol),
    .i_consume        (i_consume),
    .resp_valid       (resp_valid),
    .resp_consume     (resp_consume),
    .inflight         (inflight),
    .framing_err      (framing_err),
    .err_cnt0         (err_cnt0),
    .err_cnt1         (err_cnt1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Streams one codeword on channel ch; entered and left just after a rising edge.
  task automatic send_cw(input int ch, input int nb, input bit give_end,
                         input logic [7:0] base, output int f, output int l);
    int t;
    bit acc;
    logic [7:0] e;
    f = -1;
    l = -1;
    for (int b = 0; b < nb; b++) begin
      acc     = 1'b0;
      t       = 0;
      e       = base + 8'(b);
      rv[ch]  = 1'b1;
      rs[ch]  = (b == 0);
      re[ch]  = give_end && (b == nb - 1);
      sym[ch] = e;
      while (!acc) begin
        @(negedge clk);
        if (req_ready[ch]) begin
          acc = 1'b1;
          chk($sformatf("fwd_sym_ch%0d_b%0d", ch, b), 32'(i_symbol), 32'(e));
          chk($sformatf("fwd_end_ch%0d_b%0d", ch, b), 32'(i_end_codeword),
              32'((give_end && (b == nb - 1)) || (b == 14)));
          if (b == 0) f = cyc + 1;
          l = cyc + 1;
        end else if (++t > 300) begin
          chk($sformatf("send_timeout_ch%0d", ch), 32'(0), 32'(1));
          @(posedge clk); #1;
          rv[ch] = 1'b0; rs[ch] = 1'b0; re[ch] = 1'b0;
          return;
        end
        @(posedge clk); #1;
      end
    end
    rv[ch] = 1'b0; rs[ch] = 1'b0; re[ch] = 1'b0;
  endtask

  // Plays one decoded codeword from the decoder side and checks its routing.
  task automatic ret_cw(input int nb, input int tag, input int err_beat, output int p);
    int t;
    bit acc;
    p = -1;
    for (int b = 0; b < nb; b++) begin
      acc              = 1'b0;
      t                = 0;
      o_valid          = 1'b1;
      o_start_codeword = (b == 0);
      o_end_codeword   = (b == nb - 1);
      o_error          = (b == err_beat);
      o_symbol         = 8'(b);
      while (!acc) begin
        @(negedge clk);
        if (i_consume) begin
          acc = 1'b1;
          chk($sformatf("resp_valid_tag%0d_b%0d", tag, b), 32'(resp_valid),
              (tag == 1) ? 32'd2 : 32'd1);
          p = cyc + 1;
        end else if (++t > 300) begin
          chk("ret_timeout", 32'(0), 32'(1));
          @(posedge clk); #1;
          o_valid = 1'b0; o_end_codeword = 1'b0; o_error = 1'b0;
          return;
        end
        @(posedge clk); #1;
      end
    end
    o_valid = 1'b0; o_start_codeword = 1'b0; o_end_codeword = 1'b0; o_error = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      rv[c] = 1'b0; rs[c] = 1'b0; re[c] = 1'b0; sym[c] = 8'h0;
    end
    o_in_ready = 1'b1;
    o_valid = 1'b0; o_start_codeword = 1'b0; o_end_codeword = 1'b0;
    o_error = 1'b0; o_symbol = 8'h0;
    resp_consume = 2'b11;
    repeat (2) @(posedge clk);
    #1;

    // Reset: outputs forced low even with stimulus that would otherwise raise them.
    rv[0] = 1'b1; o_valid = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_i_consume", 32'(i_consume), 32'(0));
    chk("rst_i_valid", 32'(i_valid), 32'(0));
    chk("rst_resp_valid", 32'(resp_valid), 32'(0));
    chk("rst_inflight", 32'(inflight), 32'(0));
    chk("rst_framing_err", 32'(framing_err), 32'(0));
    chk("rst_err_cnt0", 32'(err_cnt0), 32'(0));
    chk("rst_err_cnt1", 32'(err_cnt1), 32'(0));
    rv[0] = 1'b0; o_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // T2: simultaneous starts, rr_ptr=0 -> ch0 then ch1.
    fork
      send_cw(0, 4, 1'b1, 8'h10, f0, l0);
      send_cw(1, 4, 1'b1, 8'h20, f1, l1);
    join
    chk("t2_ch0_before_ch1", 32'(f0 < f1), 32'(1));
    chk("t2_ch1_after_bubble", 32'(f1), 32'(l0 + 2));
    chk("t2_inflight_peak", 32'(inflight), 32'(2));
    ret_cw(4, 0, -1, pc);
    ret_cw(4, 1, -1, pc);
    chk("t2_inflight_drained", 32'(inflight), 32'(0));

    // T1: two 15-beat ch0 codewords, one bubble cycle between them.
    send_cw(0, 15, 1'b1, 8'h30, f0, l0);
    send_cw(0, 15, 1'b1, 8'h50, f1, l1);
    chk("t1_back_to_back", 32'(l0 - f0), 32'(14));
    chk("t1_bubble", 32'(f1), 32'(l0 + 2));
    chk("t1_inflight", 32'(inflight), 32'(2));
    ret_cw(15, 0, -1, pc);
    ret_cw(15, 0, -1, pc);
    chk("t1_inflight_drained", 32'(inflight), 32'(0));

    // T3: sinks stall; fifth codeword held until first pop.
    resp_consume = 2'b00;
    for (int i = 0; i < 4; i++) send_cw(0, 2, 1'b1, 8'h60 + 8'(2 * i), f0, l0);
    chk("t3_inflight_full", 32'(inflight), 32'(4));
    fork
      send_cw(0, 2, 1'b1, 8'h70, f0, l0);
      begin
        repeat (6) @(negedge clk);
        chk("t3_held_i_valid", 32'(i_valid), 32'(0));
        chk("t3_held_ready", 32'(req_ready), 32'(0));
        chk("t3_held_inflight", 32'(inflight), 32'(4));
        @(posedge clk); #1;
        resp_consume = 2'b11;
        ret_cw(2, 0, -1, pc);
      end
    join
    chk("t3_grant_after_pop", 32'(f0), 32'(pc + 2));
    chk("t3_inflight_refill", 32'(inflight), 32'(4));
    for (int i = 0; i < 4; i++) ret_cw(2, 0, -1, pc);
    chk("t3_inflight_drained", 32'(inflight), 32'(0));

    // T4: ch1 sends 15 beats without req_end.
    chk("t4_ferr_before", 32'(framing_err), 32'(0));
    send_cw(1, 15, 1'b0, 8'h80, f0, l0);
    chk("t4_ferr_after", 32'(framing_err), 32'(1));
    send_cw(0, 2, 1'b1, 8'h90, f1, l1);
    chk("t4_back_to_idle", 32'(f1), 32'(l0 + 2));
    ret_cw(15, 1, -1, pc);
    ret_cw(2, 0, -1, pc);
    chk("t4_inflight_drained", 32'(inflight), 32'(0));

    // T5: reset in the middle of a ch1 codeword.
    send_cw(1, 7, 1'b0, 8'hA0, f0, l0);
    chk("t5_inflight_pre", 32'(inflight), 32'(1));
    rv[1] = 1'b1; sym[1] = 8'hA7;
    rst = 1'b1;
    #1;
    chk("t5_rst_i_valid", 32'(i_valid), 32'(0));
    chk("t5_rst_i_symbol", 32'(i_symbol), 32'(0));
    chk("t5_rst_req_ready", 32'(req_ready), 32'(0));
    chk("t5_rst_inflight", 32'(inflight), 32'(0));
    chk("t5_rst_framing_err", 32'(framing_err), 32'(0));
    rv[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    fork
      send_cw(0, 3, 1'b1, 8'hB0, f0, l0);
      send_cw(1, 3, 1'b1, 8'hC0, f1, l1);
    join
    chk("t5_ch0_first", 32'(f1), 32'(l0 + 2));
    ret_cw(3, 0, -1, pc);
    ret_cw(3, 1, -1, pc);
    chk("t5_inflight_drained", 32'(inflight), 32'(0));

    // T6: errored codewords (beat 3 on ch1, end beat on ch0).
    send_cw(1, 4, 1'b1, 8'hD0, f0, l0);
    ret_cw(4, 1, 2, pc);
    chk("t6_err_cnt1", 32'(err_cnt1), 32'(ERR_EN));
    chk("t6_err_cnt0", 32'(err_cnt0), 32'(0));
    send_cw(0, 3, 1'b1, 8'hE0, f0, l0);
    ret_cw(3, 0, 2, pc);
    chk("t6_err_cnt0_end", 32'(err_cnt0), 32'(ERR_EN));
    chk("t6_err_cnt1_hold", 32'(err_cnt1), 32'(ERR_EN));

    // Decoder output with no outstanding tag is drained and flagged.
    chk("drain_ferr_before", 32'(framing_err), 32'(0));
    o_valid = 1'b1; o_end_codeword = 1'b1;
    #1;
    chk("drain_i_consume", 32'(i_consume), 32'(1));
    chk("drain_resp_valid", 32'(resp_valid), 32'(0));
    @(posedge clk); #1;
    o_valid = 1'b0; o_end_codeword = 1'b0;
    chk("drain_ferr_after", 32'(framing_err), 32'(1));
    chk("drain_inflight", 32'(inflight), 32'(0));

    // Start-less beat in IDLE is accepted and dropped.
    rv[0] = 1'b1;
    #1;
    chk("idle_drop_ready", 32'(req_ready), 32'(1));
    chk("idle_drop_i_valid", 32'(i_valid), 32'(0));
    rv[0] = 1'b0;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
